jtframe_prio_colmix: RTL and testbench
======================================

Name: jtframe_prio_colmix

Overview:
- Generalised colour mixer for multi-layer tile/sprite cores.
- Merges LAYERS pixel streams under a run-time programmable priority order and looks up a CPU-writable byte-wide palette with two sequenced byte reads per pixel.
- Outputs blank-gated RGB of configurable depth.
- Sits between the layer generators and the video output.

Parameters:
- LAYERS, 3, number of layer inputs (2..4); layer index is 2 bits.
- PW, 6, pixel index width per layer, including colour bank bits.
- TB, 3, low pixel bits tested for transparency (0 = transparent).
- CW, 4, bits per colour channel (4 or 5).
- SIMFILE, "pal.bin", palette initial contents for simulation.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pxl_cen  in  1  pixel clock enable; must be at least 4 clk apart
- LHBL  in  1  horizontal blank, active low
- LVBL  in  1  vertical blank, active low
- layer_pxl  in  LAYERS*PW  packed pixels; layer i at [i*PW+:PW]
- prio  in  LAYERS*2  slot k = layer index at priority k; slot 0 is highest
- gfx_en  in  LAYERS  per-layer enable; a disabled layer counts as transparent
- pal_cs  in  1  palette chip select
- cpu_wrn  in  1  CPU write strobe, active low
- cpu_addr  in  PW+3  byte address = {layer, pixel, byte_sel}
- cpu_dout  in  8  CPU write data
- pal_dout  out  8  CPU read data, registered, 1 clk latency
- red, green, blue  out  CW each  pixel colour
- LHBL_dly, LVBL_dly  out  1 each  blanking delayed to match colour

Behaviour:
- Reset (rst_n low, async): red/green/blue = 0, LHBL_dly = LVBL_dly = 0, sequencer to IDLE, colour word = 0. Palette contents are not cleared.
- Palette RAM: dual port, 2^(PW+3) bytes.
  - CPU port writes when pal_cs & ~cpu_wrn.
  - Video port is read-only; both ports have 1 clk read latency.
- Priority resolve, combinational at each pxl_cen:
  - Scan slots 0..LAYERS-1; pick the first layer whose pixel[TB-1:0] != 0 and whose gfx_en bit is 1.
  - If none qualifies: use the layer in the lowest-priority slot with its raw pixel, including index 0 (backdrop).
  - If that layer is disabled: use address {layer, PW'0}.
  - Duplicate layer indices in prio are legal; the first match wins.
- Sequencer, states IDLE, LO, HI, CAP:
  - pxl_cen: register pal_a = {layer, pixel}; sample LHBL/LVBL; state -> LO; video address = {pal_a, 0}.
  - LO -> HI: video address = {pal_a, 1}.
  - HI -> CAP: capture q as low byte.
  - CAP -> IDLE: capture q as high byte; pending colour word complete.
- pxl_cen in any non-IDLE state restarts at LO with the new pal_a. The pending word is not updated, so the previous colour repeats.
- Colour format, CW=4:
  - low byte = {G[3:0], R[3:0]}; high byte = {4'x, B[3:0]}.
- Colour format, CW=5:
  - word = {high, low}; R = word[4:0], G = word[9:5], B = word[14:10]; bit 15 ignored.
- Output stage, at the next pxl_cen:
  - red/green/blue <= pending word, or all zero if the blanking sampled with that pixel was active.
  - LHBL_dly/LVBL_dly <= those sampled values.
  - Total latency: 2 pxl_cen from layer_pxl to RGB.
- CPU access never stalls the video read; same-address simultaneous write/read returns old data on the video port.

Optional Feature:
- Macro: JTFRAME_COLMIX_DIM_EN.
- Defined:
  - Adds input dim (4 bits).
  - Each channel at the output stage becomes (chan * (16 - dim)) >> 4, truncated, computed in one clk before the output register. Latency is unchanged because it fits in the IDLE slack.
  - dim = 0 gives identity; dim = 15 gives chan >> 4 (0 for CW ≤ 4).
- Undefined: no dim port; channels pass unmodified.

Test Plan:
- Reset mid-sequence: assert rst_n low 2 clk after pxl_cen -> RGB = 0, LHBL_dly = 0 immediately; after release, first pixel out only after 2 pxl_cen.
- Priority swap: LAYERS=3, layer0 px 0x05, layer1 px 0x03, prio {2,1,0} then {2,0,1} -> palette address layer0:0x05 then layer1:0x03. With palette bytes written as G=0xA, R=0x5, B=0xC, output R=5, G=A, B=C at the second pxl_cen.
- Transparency/backdrop: all layers px 0x08 (low 3 bits 0), lowest slot layer 2 -> address {2, 0x08}; gfx_en=0 on layer 2 -> address {2, 0}.
- Blank gating: LHBL=0 at sample -> RGB 0 and LHBL_dly=0 exactly 2 pxl_cen later, even with a non-zero palette entry.
- pxl_cen overrun: pxl_cen 2 clk apart -> sequence restarts; output repeats the previous colour, no corrupted byte mix.
- CW=5 with DIM_EN: word 0x7FFF, dim=8 -> R=G=B=15.

Source files
------------

// File: rtl/jtframe_prio_colmix_if.sv
// jtframe_prio_colmix_if
// ----------------------
// CPU-side palette bus for jtframe_prio_colmix.
//
// Signals:
//   pal_cs    palette chip select
//   cpu_wrn   write strobe, active low
//   cpu_addr  byte address {layer[1:0], pixel[PW-1:0], byte_sel}
//   cpu_dout  write data from the CPU
//   pal_dout  read data to the CPU, one clk after the address
//
// Modports:
//   master  CPU / bus owner
//   slave   colour mixer palette port
interface jtframe_prio_colmix_if #(
    parameter int unsigned PW = 6
);
    logic          pal_cs;
    logic          cpu_wrn;
    logic [PW+2:0] cpu_addr;
    logic [7:0]    cpu_dout;
    logic [7:0]    pal_dout;

    modport master (
        output pal_cs,
        output cpu_wrn,
        output cpu_addr,
        output cpu_dout,
        input  pal_dout
    );

    modport slave (
        input  pal_cs,
        input  cpu_wrn,
        input  cpu_addr,
        input  cpu_dout,
        output pal_dout
    );
endinterface

// File: rtl/jtframe_prio_colmix.sv
// jtframe_prio_colmix
// -------------------
// Priority-resolving colour mixer for multi-layer tile/sprite cores. Picks one pixel out of
// LAYERS streams using a run-time priority table, fetches its colour from a byte-wide
// palette RAM as two sequenced byte reads, and emits blank-gated RGB.
//
// Optional build macro: JTFRAME_COLMIX_DIM_EN adds a 4-bit 'dim' input that scales each
// channel by (16 - dim) / 16 while the colour word is committed.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   pxl_cen           pixel clock enable, at least 4 clk apart
//   LHBL, LVBL        horizontal / vertical blank, active low
//   layer_pxl         packed layer pixels, layer i at [i*PW +: PW]
//   prio              slot k holds the layer index at priority k, slot 0 highest
//   gfx_en            per-layer enable, a disabled layer is treated as transparent
//   dim               (JTFRAME_COLMIX_DIM_EN only) output attenuation
//   cpu               palette CPU bus (slave modport)
//   red, green, blue  pixel colour, CW bits each
//   LHBL_dly, LVBL_dly blanking aligned with the colour outputs
//
// Pipeline: layer_pxl is sampled at one pxl_cen, the palette word is fetched in the four clk
// that follow, and the colour reaches the outputs at the next pxl_cen.
module jtframe_prio_colmix #(
    parameter int unsigned LAYERS  = 3,
    parameter int unsigned PW      = 6,
    parameter int unsigned TB      = 3,
    parameter int unsigned CW      = 4,
    parameter string       SIMFILE = "pal.bin"
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pxl_cen,
    input  logic                 LHBL,
    input  logic                 LVBL,
    input  logic [LAYERS*PW-1:0] layer_pxl,
    input  logic [LAYERS*2-1:0]  prio,
    input  logic [LAYERS-1:0]    gfx_en,
`ifdef JTFRAME_COLMIX_DIM_EN
    input  logic [3:0]           dim,
`endif
    jtframe_prio_colmix_if.slave cpu,
    output logic [CW-1:0]        red,
    output logic [CW-1:0]        green,
    output logic [CW-1:0]        blue,
    output logic                 LHBL_dly,
    output logic                 LVBL_dly
);

    localparam int unsigned AW = PW + 3;  // palette byte address width
    localparam int unsigned PA = PW + 2;  // palette entry address {layer, pixel}

    typedef enum logic [1:0] {StIdle, StLo, StHi, StCap} state_e;

    // Palette contents are loaded through the CPU port; the file name is only carried so
    // existing instantiations keep elaborating.
    logic unused_simfile;
    assign unused_simfile = (SIMFILE == "");

    // ---------------------------------------------------------------------------------------
    // Priority resolve
    // ---------------------------------------------------------------------------------------
    // Pad to four layers so any 2-bit index in prio selects something defined: a missing
    // layer reads as a disabled, transparent one.
    logic [4*PW-1:0] pxl_pad;
    logic [3:0]      en_pad;
    logic [PW-1:0]   lyr_px [4];

    assign pxl_pad = (4*PW)'(layer_pxl);
    assign en_pad  = 4'(gfx_en);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lyr_px[i] = pxl_pad[i*PW +: PW];
        end
    end

    logic          found;
    logic [1:0]    slot;
    logic [1:0]    sel_lyr;
    logic [PW-1:0] sel_pxl;
    logic [PA-1:0] pal_nxt;

    always_comb begin
        found = 1'b0;
        slot  = '0;
        // Backdrop: lowest-priority slot with its raw pixel, or entry 0 if that layer is off.
        sel_lyr = prio[2*(LAYERS-1) +: 2];
        sel_pxl = en_pad[sel_lyr] ? lyr_px[sel_lyr] : '0;
        for (int k = 0; k < int'(LAYERS); k++) begin
            slot = prio[2*k +: 2];
            if (!found && en_pad[slot] && (lyr_px[slot][TB-1:0] != '0)) begin
                found   = 1'b1;
                sel_lyr = slot;
                sel_pxl = lyr_px[slot];
            end
        end
    end

    assign pal_nxt = {sel_lyr, sel_pxl};

    // ---------------------------------------------------------------------------------------
    // Palette RAM: CPU read/write port and video read-only port, both 1 clk latency
    // ---------------------------------------------------------------------------------------
    logic [7:0]    mem [2**AW];
    logic [7:0]    vid_q;
    logic [AW-1:0] vid_addr_q;

    // Reads sample the array before this edge's write lands, so a colliding address returns
    // the old byte on both ports.
    always_ff @(posedge clk) begin
        if (cpu.pal_cs && !cpu.cpu_wrn) begin
            mem[cpu.cpu_addr] <= cpu.cpu_dout;
        end
        cpu.pal_dout <= mem[cpu.cpu_addr];
        vid_q        <= mem[vid_addr_q];
    end

    // ---------------------------------------------------------------------------------------
    // Fetch sequencer
    // ---------------------------------------------------------------------------------------
    state_e        state_q;
    logic [PA-1:0] pal_a_q;
    logic [7:0]    low_q;
    logic          hbl_q;
    logic          vbl_q;
    logic [CW-1:0] pend_r_q;
    logic [CW-1:0] pend_g_q;
    logic [CW-1:0] pend_b_q;
    logic [15:0]   word;

    assign word = {vid_q, low_q};

    // Bits above the three channels carry no colour.
    logic unused_word;
    assign unused_word = ^word[15:3*CW];

`ifdef JTFRAME_COLMIX_DIM_EN
    function automatic logic [CW-1:0] dim_chan(input logic [CW-1:0] chan,
                                               input logic [3:0]    lvl);
        logic [CW+3:0] prod;
        // Largest product is (2^CW - 1) * 16, which fits in CW+4 bits.
        prod = (CW+4)'(chan) * (CW+4)'(5'd16 - {1'b0, lvl});
        return CW'(prod >> 4);
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pal_a_q    <= '0;
            vid_addr_q <= '0;
            low_q      <= '0;
            hbl_q      <= 1'b0;
            vbl_q      <= 1'b0;
            pend_r_q   <= '0;
            pend_g_q   <= '0;
            pend_b_q   <= '0;
        end else if (pxl_cen) begin
            // A new pixel always wins; an unfinished fetch is dropped and the previously
            // committed colour stays pending.
            pal_a_q    <= pal_nxt;
            vid_addr_q <= {pal_nxt, 1'b0};
            hbl_q      <= LHBL;
            vbl_q      <= LVBL;
            state_q    <= StLo;
        end else begin
            unique case (state_q)
                StLo: begin
                    vid_addr_q <= {pal_a_q, 1'b1};
                    state_q    <= StHi;
                end
                StHi: begin
                    low_q   <= vid_q;
                    state_q <= StCap;
                end
                StCap: begin
`ifdef JTFRAME_COLMIX_DIM_EN
                    pend_r_q <= dim_chan(word[0    +: CW], dim);
                    pend_g_q <= dim_chan(word[CW   +: CW], dim);
                    pend_b_q <= dim_chan(word[2*CW +: CW], dim);
`else
                    pend_r_q <= word[0    +: CW];
                    pend_g_q <= word[CW   +: CW];
                    pend_b_q <= word[2*CW +: CW];
`endif
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------------------------
    // Output stage
    // ---------------------------------------------------------------------------------------
    logic show;
    assign show = hbl_q & vbl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red      <= '0;
            green    <= '0;
            blue     <= '0;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
        end else if (pxl_cen) begin
            red      <= show ? pend_r_q : '0;
            green    <= show ? pend_g_q : '0;
            blue     <= show ? pend_b_q : '0;
            LHBL_dly <= hbl_q;
            LVBL_dly <= vbl_q;
        end
    end

endmodule

// File: tb/tb_jtframe_prio_colmix.sv
// tb_jtframe_prio_colmix
// ----------------------
// Directed bench for jtframe_prio_colmix (LAYERS=3, PW=6, TB=3, CW=4). Expected colours are
// hand-derived from the palette bytes loaded below.
module tb_jtframe_prio_colmix;

    localparam int unsigned LAYERS = 3;
    localparam int unsigned PW     = 6;
    localparam int unsigned TB     = 3;
    localparam int unsigned CW     = 4;

    // Expected {R,G,B} per palette entry loaded in load_palette.
    localparam logic [11:0] C_A0 = 12'h5AC;  // layer0 px 0x05
    localparam logic [11:0] C_A1 = 12'h123;  // layer1 px 0x03
    localparam logic [11:0] C_A2 = 12'h678;  // layer2 px 0x08
    localparam logic [11:0] C_A3 = 12'hE9D;  // layer2 px 0x00
    localparam logic [11:0] C_A4 = 12'hB34;  // layer0 px 0x00

    localparam logic [17:0] PX_MIX = {6'h08, 6'h03, 6'h05};
    localparam logic [17:0] PX_08  = {6'h08, 6'h08, 6'h08};
    localparam logic [17:0] PX_DUP = {6'h08, 6'h08, 6'h05};
    localparam logic [17:0] PX_BD  = {6'h08, 6'h08, 6'h00};
    localparam logic [5:0]  PR210  = {2'd2, 2'd1, 2'd0};
    localparam logic [5:0]  PR201  = {2'd2, 2'd0, 2'd1};
    localparam logic [5:0]  PR011  = {2'd0, 2'd1, 2'd1};
    localparam logic [5:0]  PR012  = {2'd0, 2'd1, 2'd2};

    typedef struct packed {
        logic [17:0] px;
        logic [5:0]  pr;
        logic [2:0]  en;
        logic        hbl;
        logic        vbl;
        logic [11:0] rgb;  // colour expected one pxl_cen after this vector is sampled
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 pxl_cen = 1'b0;
    logic                 LHBL = 1'b0;
    logic                 LVBL = 1'b0;
    logic [LAYERS*PW-1:0] layer_pxl = '0;
    logic [LAYERS*2-1:0]  prio = '0;
    logic [LAYERS-1:0]    gfx_en = '0;
`ifdef JTFRAME_COLMIX_DIM_EN
    logic [3:0]           dim = 4'd0;
`endif
    logic [CW-1:0]        red;
    logic [CW-1:0]        green;
    logic [CW-1:0]        blue;
    logic                 LHBL_dly;
    logic                 LVBL_dly;

    int n_cmp = 0;
    int n_bad = 0;

    jtframe_prio_colmix_if #(.PW(PW)) cpu_bus ();

    jtframe_prio_colmix #(
        .LAYERS (LAYERS),
        .PW     (PW),
        .TB     (TB),
        .CW     (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pxl_cen   (pxl_cen),
        .LHBL      (LHBL),
        .LVBL      (LVBL),
        .layer_pxl (layer_pxl),
        .prio      (prio),
        .gfx_en    (gfx_en),
`ifdef JTFRAME_COLMIX_DIM_EN
        .dim       (dim),
`endif
        .cpu       (cpu_bus),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .LHBL_dly  (LHBL_dly),
        .LVBL_dly  (LVBL_dly)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        layer_pxl = v.px;
        prio      = v.pr;
        gfx_en    = v.en;
        LHBL      = v.hbl;
        LVBL      = v.vbl;
    endtask

    // One pxl_cen followed by gap-1 idle clk.
    task automatic pixel_step(input int gap);
        pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic cpu_wr(input logic [8:0] a, input logic [7:0] d, input logic cs);
        cpu_bus.pal_cs   = cs;
        cpu_bus.cpu_wrn  = 1'b0;
        cpu_bus.cpu_addr = a;
        cpu_bus.cpu_dout = d;
        tick();
        cpu_bus.pal_cs   = 1'b0;
        cpu_bus.cpu_wrn  = 1'b1;
    endtask

    task automatic load_palette;
        cpu_wr(9'h00A, 8'hA5, 1'b1);  // layer0 px 05: G=A R=5
        cpu_wr(9'h00B, 8'hFC, 1'b1);  // B=C, upper nibble ignored
        cpu_wr(9'h086, 8'h21, 1'b1);  // layer1 px 03
        cpu_wr(9'h087, 8'h03, 1'b1);
        cpu_wr(9'h110, 8'h76, 1'b1);  // layer2 px 08
        cpu_wr(9'h111, 8'h08, 1'b1);
        cpu_wr(9'h100, 8'h9E, 1'b1);  // layer2 px 00
        cpu_wr(9'h101, 8'h0D, 1'b1);
        cpu_wr(9'h000, 8'h3B, 1'b1);  // layer0 px 00
        cpu_wr(9'h001, 8'h04, 1'b1);
    endtask

    task automatic test_reset;
        tick();
        tick();
        n_cmp++;
        if ({red, green, blue} !== 12'h000) begin
            $display("FAIL reset_rgb: got %h want 000", {red, green, blue});
            n_bad++;
        end
        n_cmp++;
        if ({LHBL_dly, LVBL_dly} !== 2'b00) begin
            $display("FAIL reset_blank: got %b want 00", {LHBL_dly, LVBL_dly});
            n_bad++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cpu_port;
        logic [8:0] ra [3];
        logic [7:0] rd [3];
        cpu_wr(9'h00A, 8'h55, 1'b0);  // no chip select: must not write
        ra[0] = 9'h00A; rd[0] = 8'hA5;
        ra[1] = 9'h087; rd[1] = 8'h03;
        ra[2] = 9'h110; rd[2] = 8'h76;
        for (int i = 0; i < 3; i++) begin
            cpu_bus.pal_cs   = 1'b1;
            cpu_bus.cpu_wrn  = 1'b1;
            cpu_bus.cpu_addr = ra[i];
            tick();
            n_cmp++;
            if (cpu_bus.pal_dout !== rd[i]) begin
                $display("FAIL cpu_read[%0d]: got %h want %h", i, cpu_bus.pal_dout, rd[i]);
                n_bad++;
            end
        end
        cpu_bus.pal_cs = 1'b0;
    endtask

    task automatic test_priority;
        vec_t v [5];
        v[0] = '{PX_MIX, PR210, 3'b111, 1'b1, 1'b1, C_A0};
        v[1] = '{PX_MIX, PR201, 3'b111, 1'b1, 1'b1, C_A1};
        v[2] = '{PX_MIX, PR210, 3'b111, 1'b1, 1'b1, C_A0};
        v[3] = '{PX_MIX, PR210, 3'b110, 1'b1, 1'b1, C_A1};  // layer0 disabled
        v[4] = '{PX_MIX, PR210, 3'b111, 1'b1, 1'b1, C_A0};
        for (int k = 0; k < 5; k++) begin
            apply(v[k]);
            pixel_step(4);
            if (k > 0) begin
                n_cmp++;
                if ({red, green, blue} !== v[k-1].rgb) begin
                    $display("FAIL priority[%0d]: got %h want %h", k - 1, {red, green, blue},
                             v[k-1].rgb);
                    n_bad++;
                end
            end
        end
    endtask

    task automatic test_transparency;
        vec_t v [5];
        v[0] = '{PX_08,  PR210, 3'b111, 1'b1, 1'b1, C_A2};  // backdrop with raw pixel
        v[1] = '{PX_08,  PR210, 3'b011, 1'b1, 1'b1, C_A3};  // backdrop layer disabled
        v[2] = '{PX_DUP, PR011, 3'b011, 1'b1, 1'b1, C_A0};  // duplicate slots
        v[3] = '{PX_BD,  PR012, 3'b111, 1'b1, 1'b1, C_A4};  // backdrop pixel index 0
        v[4] = '{PX_MIX, PR210, 3'b111, 1'b1, 1'b1, C_A0};
        for (int k = 0; k < 5; k++) begin
            apply(v[k]);
            pixel_step(4);
            if (k > 0) begin
                n_cmp++;
                if ({red, green, blue} !== v[k-1].rgb) begin
                    $display("FAIL transparency[%0d]: got %h want %h", k - 1,
                             {red, green, blue}, v[k-1].rgb);
                    n_bad++;
                end
            end
        end
    endtask

    task automatic test_blank;
        vec_t v [5];
        v[0] = '{PX_MIX, PR210, 3'b111, 1'b0, 1'b1, 12'h000};
        v[1] = '{PX_MIX, PR201, 3'b111, 1'b1, 1'b1, C_A1};
        v[2] = '{PX_MIX, PR210, 3'b111, 1'b1, 1'b0, 12'h000};
        v[3] = '{PX_08,  PR210, 3'b111, 1'b1, 1'b1, C_A2};
        v[4] = '{PX_MIX, PR210, 3'b111, 1'b1, 1'b1, C_A0};
        for (int k = 0; k < 5; k++) begin
            apply(v[k]);
            pixel_step(4);
            if (k > 0) begin
                n_cmp++;
                if ({red, green, blue} !== v[k-1].rgb) begin
                    $display("FAIL blank_rgb[%0d]: got %h want %h", k - 1, {red, green, blue},
                             v[k-1].rgb);
                    n_bad++;
                end
                n_cmp++;
                if ({LHBL_dly, LVBL_dly} !== {v[k-1].hbl, v[k-1].vbl}) begin
                    $display("FAIL blank_dly[%0d]: got %b want %b", k - 1,
                             {LHBL_dly, LVBL_dly}, {v[k-1].hbl, v[k-1].vbl});
                    n_bad++;
                end
            end
        end
    endtask

    task automatic test_overrun;
        apply('{PX_MIX, PR201, 3'b111, 1'b1, 1'b1, C_A1});
        pixel_step(4);
        apply('{PX_MIX, PR210, 3'b111, 1'b1, 1'b1, C_A0});
        pixel_step(2);  // cut short: A0 never commits
        n_cmp++;
        if ({red, green, blue} !== C_A1) begin
            $display("FAIL overrun_prev: got %h want %h", {red, green, blue}, C_A1);
            n_bad++;
        end
        apply('{PX_08, PR210, 3'b111, 1'b1, 1'b1, C_A2});
        pixel_step(4);
        n_cmp++;
        if ({red, green, blue} !== C_A1) begin
            $display("FAIL overrun_repeat: got %h want %h", {red, green, blue}, C_A1);
            n_bad++;
        end
        apply('{PX_MIX, PR201, 3'b111, 1'b1, 1'b1, C_A1});
        pixel_step(4);
        n_cmp++;
        if ({red, green, blue} !== C_A2) begin
            $display("FAIL overrun_recover: got %h want %h", {red, green, blue}, C_A2);
            n_bad++;
        end
    endtask

    task automatic test_reset_mid;
        apply('{PX_MIX, PR210, 3'b111, 1'b1, 1'b1, C_A0});
        pixel_step(4);
        apply('{PX_MIX, PR201, 3'b111, 1'b1, 1'b1, C_A1});
        pixel_step(4);
        n_cmp++;
        if ({red, green, blue} !== C_A0) begin
            $display("FAIL rstmid_pre: got %h want %h", {red, green, blue}, C_A0);
            n_bad++;
        end
        apply('{PX_08, PR210, 3'b111, 1'b1, 1'b1, C_A2});
        pixel_step(3);  // now 2 clk after the pxl_cen edge
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({red, green, blue, LHBL_dly, LVBL_dly} !== 14'h0) begin
            $display("FAIL rstmid_async: got rgb=%h dly=%b want 000/00", {red, green, blue},
                     {LHBL_dly, LVBL_dly});
            n_bad++;
        end
        tick();
        rst_n = 1'b1;
        apply('{PX_MIX, PR201, 3'b111, 1'b1, 1'b1, C_A1});
        pixel_step(4);
        n_cmp++;
        if ({red, green, blue, LHBL_dly} !== 13'h0) begin
            $display("FAIL rstmid_first: got rgb=%h hdly=%b want 000/0", {red, green, blue},
                     LHBL_dly);
            n_bad++;
        end
        apply('{PX_MIX, PR210, 3'b111, 1'b1, 1'b1, C_A0});
        pixel_step(4);
        n_cmp++;
        if ({red, green, blue, LHBL_dly} !== {C_A1, 1'b1}) begin
            $display("FAIL rstmid_second: got rgb=%h hdly=%b want %h/1", {red, green, blue},
                     LHBL_dly, C_A1);
            n_bad++;
        end
    endtask

`ifdef JTFRAME_COLMIX_DIM_EN
    task automatic test_dim;
        dim = 4'd8;  // halve: 5->2, A->5, C->6
        apply('{PX_MIX, PR210, 3'b111, 1'b1, 1'b1, C_A0});
        pixel_step(4);
        dim = 4'd15;  // 1/16 of a 4-bit channel truncates to 0
        apply('{PX_MIX, PR201, 3'b111, 1'b1, 1'b1, C_A1});
        pixel_step(4);
        n_cmp++;
        if ({red, green, blue} !== 12'h256) begin
            $display("FAIL dim_half: got %h want 256", {red, green, blue});
            n_bad++;
        end
        dim = 4'd0;
        pixel_step(4);
        n_cmp++;
        if ({red, green, blue} !== 12'h000) begin
            $display("FAIL dim_max: got %h want 000", {red, green, blue});
            n_bad++;
        end
        pixel_step(4);
        n_cmp++;
        if ({red, green, blue} !== C_A1) begin
            $display("FAIL dim_zero: got %h want %h", {red, green, blue}, C_A1);
            n_bad++;
        end
    endtask
`endif

    initial begin
        cpu_bus.pal_cs   = 1'b0;
        cpu_bus.cpu_wrn  = 1'b1;
        cpu_bus.cpu_addr = '0;
        cpu_bus.cpu_dout = '0;
        test_reset();
        load_palette();
        test_cpu_port();
        test_priority();
        test_transparency();
        test_blank();
        test_overrun();
        test_reset_mid();
`ifdef JTFRAME_COLMIX_DIM_EN
        test_dim();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
